// File: rtl/wave_channel_if.sv
// Control, wave-RAM write port and sample output of one wave_channel voice.
// The owner of the voice's registers drives master; the channel itself is the slave.
interface wave_channel_if #(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  parameter int FREQ_W   = 11,
  parameter int LEN_W    = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                len_tick;
  logic                dac_en;
  logic [FREQ_W-1:0]   freq;
  logic [1:0]          vol_code;
  logic                len_load;
  logic [LEN_W-1:0]    len_val;
  logic                len_enable;
  logic                trigger;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                wr_bank;
  logic                play_bank;
  logic [SAMPLE_W-1:0] out;
  logic                active;

  modport master (
    output len_tick, dac_en, freq, vol_code, len_load, len_val, len_enable,
           trigger, wr_en, wr_addr, wr_data, wr_bank, play_bank,
    input  out, active
  );

  modport slave (
    input  len_tick, dac_en, freq, vol_code, len_load, len_val, len_enable,
           trigger, wr_en, wr_addr, wr_data, wr_bank, play_bank,
    output out, active
  );
endinterface

// File: rtl/wave_channel.sv
// Wavetable voice: out is registered, 1 clk after pos/vol change; no backpressure, free-running stream.
// WAVE_DUAL_BANK_EN adds a second table bank swapped only on trigger or position wrap.
module wave_channel #(
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 32,
  parameter int FREQ_W   = 11,
  parameter int LEN_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  wave_channel_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = FREQ_W + 2;
  localparam int CW = LEN_W + 1;
`ifdef WAVE_DUAL_BANK_EN
  localparam int RAW = AW + 1;
`else
  localparam int RAW = AW;
`endif
  localparam int RAM_D = 1 << RAW;
  localparam logic [CW-1:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  logic [SAMPLE_W-1:0] ram [RAM_D];
  logic [SAMPLE_W-1:0] rd_data;
  logic [SAMPLE_W-1:0] shaped;
  logic [SAMPLE_W-1:0] out_q;
  logic [RAW-1:0]      rd_addr;
  logic [RAW-1:0]      wr_addr_full;
  logic [AW-1:0]       pos;
  logic [TW-1:0]       timer;
  logic [TW-1:0]       period;
  logic [CW-1:0]       len_cnt;
  logic [CW-1:0]       len_loaded;
  logic [CW-1:0]       len_nxt;
  logic                active_q;
  logic                act_nxt;
  logic                expire;

  // P = 2*(2^FREQ_W - freq); the extra top bit holds 2^(FREQ_W+1) when freq = 0
  assign period = {({1'b1, {FREQ_W{1'b0}}} - {1'b0, bus.freq}), 1'b0};
  assign expire = active_q && (timer <= TW'(1));

  assign len_loaded = bus.len_load ? (LEN_FULL - {1'b0, bus.len_val}) : len_cnt;

  // Trigger outranks ticks; a load in the same cycle is seen by the trigger's zero check
  always_comb begin
    len_nxt = len_loaded;
    act_nxt = active_q;
    if (bus.trigger) begin
      if (len_loaded == '0) begin
        len_nxt = LEN_FULL;
      end
      act_nxt = bus.dac_en;
    end else begin
      if (bus.len_tick && bus.len_enable && !bus.len_load && (len_cnt != '0)) begin
        len_nxt = len_cnt - CW'(1);
        if (len_cnt == CW'(1)) begin
          act_nxt = 1'b0;
        end
      end
      if (!bus.dac_en) begin
        act_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    shaped = '0;
    case (bus.vol_code)
      2'd1:    shaped = rd_data;
      2'd2:    shaped = rd_data >> 1;
      2'd3:    shaped = rd_data >> 2;
      default: shaped = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos      <= '0;
      timer    <= '0;
      len_cnt  <= '0;
      active_q <= 1'b0;
      out_q    <= '0;
    end else begin
      len_cnt  <= len_nxt;
      active_q <= act_nxt;
      if (bus.trigger) begin
        pos   <= '0;
        timer <= period;
      end else if (active_q) begin
        if (expire) begin
          pos   <= pos + AW'(1);
          timer <= period;
        end else begin
          timer <= timer - TW'(1);
        end
      end
      out_q <= active_q ? shaped : '0;
    end
  end

`ifdef WAVE_DUAL_BANK_EN
  logic bank_q;
  logic wrap;

  assign wrap = expire && (pos == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
    end else if (bus.trigger || wrap) begin
      bank_q <= bus.play_bank;
    end
  end

  assign rd_addr      = {bank_q, pos};
  assign wr_addr_full = {bus.wr_bank, bus.wr_addr};
`else
  logic unused_bank;

  assign unused_bank  = bus.wr_bank ^ bus.play_bank;
  assign rd_addr      = pos;
  assign wr_addr_full = bus.wr_addr;
`endif

  // Not reset; a write to the playing address shows on out one cycle later
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      ram[wr_addr_full] <= bus.wr_data;
    end
  end

  assign rd_data    = ram[rd_addr];
  assign bus.out    = out_q;
  assign bus.active = active_q;
endmodule

// File: tb/tb_wave_channel.sv
// Scoreboard bench for wave_channel: expected samples are queued as stimulus is
// driven and popped against out on each following output cycle.
`timescale 1ns/1ps
module tb_wave_channel;
  localparam int SAMPLE_W = 4;
  localparam int DEPTH    = 32;
  localparam int FREQ_W   = 11;
  localparam int LEN_W    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_channel_if #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .FREQ_W(FREQ_W), .LEN_W(LEN_W)) bus ();

  wave_channel #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .FREQ_W(FREQ_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  int wave0 [DEPTH];
  int wave1 [DEPTH];
  int ph   = 0;
  int per  = 4;
  int peak = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int vshift(input int s, input int v);
    case (v)
      1:       return s;
      2:       return s >> 1;
      3:       return s >> 2;
      default: return 0;
    endcase
  endfunction

  task automatic expect_one(input string tag, input int val);
    exp_q.push_back(val);
    step();
    if (int'(bus.out) > peak) peak = int'(bus.out);
    chk(tag, int'(bus.out), exp_q.pop_front());
  endtask

  // Output at edge ph reflects pos from the state after edge ph-1
  task automatic play(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      ph++;
      expect_one(tag, vshift(wave0[((ph - 1) / per) % DEPTH], int'(bus.vol_code)));
    end
  endtask

  task automatic play_dual(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int idx;
      ph++;
      idx = (ph - 1) / per;
      expect_one(tag, vshift((idx >= DEPTH) ? wave1[idx % DEPTH] : wave0[idx % DEPTH],
                             int'(bus.vol_code)));
    end
  endtask

  task automatic write(input logic bank, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_bank = bank;
    bus.wr_addr = addr[$clog2(DEPTH)-1:0];
    bus.wr_data = data[SAMPLE_W-1:0];
    step();
    bus.wr_en   = 1'b0;
    bus.wr_bank = 1'b0;
  endtask

  task automatic trigger_go();
    bus.trigger = 1'b1;
    step();
    bus.trigger  = 1'b0;
    bus.len_load = 1'b0;
    ph = 0;
  endtask

  task automatic tick();
    bus.len_tick = 1'b1;
    step();
    bus.len_tick = 1'b0;
    ph++;
  endtask

  initial begin
    bus.len_tick   = 1'b0;
    bus.dac_en     = 1'b0;
    bus.freq       = '0;
    bus.vol_code   = 2'd0;
    bus.len_load   = 1'b0;
    bus.len_val    = '0;
    bus.len_enable = 1'b0;
    bus.trigger    = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_bank    = 1'b0;
    bus.play_bank  = 1'b0;

    repeat (3) step();
    chk("rst_out", int'(bus.out), 0);
    chk("rst_active", int'(bus.active), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      write(1'b0, i, i);
      wave0[i] = i;
      write(1'b0, 16 + i, 15 - i);
      wave0[16 + i] = 15 - i;
    end

    // Triangle playback at P = 4, through one full wrap
    bus.freq = 11'd2046; per = 4;
    bus.vol_code = 2'd1;
    bus.dac_en = 1'b1;
    trigger_go();
    chk("trig_active", int'(bus.active), 1);
    peak = 0;
    play(136, "play_v1");
    chk("peak_v1", peak, 15);

    bus.vol_code = 2'd2; peak = 0;
    play(128, "play_v2");
    chk("peak_v2", peak, 7);
    bus.vol_code = 2'd3; peak = 0;
    play(128, "play_v3");
    chk("peak_v3", peak, 3);
    bus.vol_code = 2'd0;
    play(4, "play_mute");

    // Length counter: load 254 with trigger -> two ticks to expiry
    bus.vol_code = 2'd1;
    bus.len_enable = 1'b1;
    bus.len_val = 8'd254;
    bus.len_load = 1'b1;
    trigger_go();
    chk("len_trig_active", int'(bus.active), 1);
    play(3, "len_play");
    tick();
    chk("len_tick1_active", int'(bus.active), 1);
    play(2, "len_play2");
    tick();
    chk("len_tick2_active", int'(bus.active), 0);
    step();
    chk("len_off_out", int'(bus.out), 0);

    trigger_go();
    chk("len256_trig", int'(bus.active), 1);
    for (int i = 0; i < 255; i++) tick();
    chk("len256_tick255", int'(bus.active), 1);
    tick();
    chk("len256_tick256", int'(bus.active), 0);
    bus.len_enable = 1'b0;

    // Write to the sample being played
    trigger_go();
    play(1, "wr_pre");
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 4'd9;
    ph++;
    expect_one("wr_old", vshift(wave0[0], 1));
    bus.wr_en = 1'b0;
    wave0[0] = 9;
    ph++;
    expect_one("wr_new", 9);
    play(10, "wr_post");

    // Shortest period, P = 2
    bus.freq = 11'd2047; per = 2;
    trigger_go();
    play(70, "play_p2");

    bus.dac_en = 1'b0;
    step();
    chk("dac_off_active", int'(bus.active), 0);
    step();
    chk("dac_off_out", int'(bus.out), 0);
    trigger_go();
    chk("trig_dac_low_active", int'(bus.active), 0);
    step();
    chk("trig_dac_low_out", int'(bus.out), 0);

    // Asynchronous reset mid-playback; RAM must survive
    bus.dac_en = 1'b1;
    bus.freq = 11'd2046; per = 4;
    trigger_go();
    play(20, "pre_rst");
    rst_n = 1'b0;
    #2;
    chk("midrst_out", int'(bus.out), 0);
    chk("midrst_active", int'(bus.active), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    trigger_go();
    play(136, "post_rst");

`ifdef WAVE_DUAL_BANK_EN
    for (int i = 0; i < DEPTH; i++) begin
      wave1[i] = (i * 5 + 3) % 16;
      write(1'b1, i, wave1[i]);
    end
    bus.play_bank = 1'b0;
    trigger_go();
    play_dual(40, "bank0");
    bus.play_bank = 1'b1;
    play_dual(160, "bank_swap");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
